// File: rtl/lc4_pkg.sv
// Shared LC4 definitions: default datapath widths and NZP condition-code encodings.
package lc4_pkg;

  localparam int unsigned LC4_DATA_W = 16;
  localparam int unsigned LC4_ADDR_W = 3;

  typedef logic [2:0] nzp_t;

  localparam nzp_t NZP_N     = 3'b100;
  localparam nzp_t NZP_Z     = 3'b010;
  localparam nzp_t NZP_P     = 3'b001;
  localparam nzp_t NZP_RESET = NZP_Z;

endpackage

// File: rtl/lc4_nzp_calc.sv
// Condition-code generator: classifies a two's-complement value as N, Z or P.
module lc4_nzp_calc
  import lc4_pkg::*;
#(
  parameter int unsigned DATA_W = LC4_DATA_W
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [2:0]        o_nzp
);

  always_comb begin
    o_nzp = NZP_P;
    if (i_data[DATA_W-1])
      o_nzp = NZP_N;
    else if (i_data == '0)
      o_nzp = NZP_Z;
  end

endmodule

// File: rtl/lc4_regfile.sv
// LC4 architectural register file with same-cycle write bypass and the NZP register.
module lc4_regfile
  import lc4_pkg::*;
#(
  parameter int unsigned DATA_W = LC4_DATA_W,
  parameter int unsigned ADDR_W = LC4_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gwe,
  input  logic [ADDR_W-1:0] i_rs,
  input  logic [ADDR_W-1:0] i_rt,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic              i_rd_we,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_nzp_we,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic [2:0]        o_nzp,
  output logic [2:0]        o_nzp_next
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [2:0]        r_nzp;
  logic              w_wr_en;
  logic              w_nzp_en;
  logic [2:0]        w_nzp_next;

  // Reset gates the bypass so reads stay at zero while rst_n is low.
  assign w_wr_en  = gwe & i_rd_we & rst_n;
  assign w_nzp_en = gwe & i_nzp_we;

  lc4_nzp_calc #(.DATA_W(DATA_W)) u_nzp_calc (
    .i_data (i_wdata),
    .o_nzp  (w_nzp_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
      r_nzp <= NZP_RESET;
    end else begin
      if (w_wr_en)
        r_regs[i_rd] <= i_wdata;
      if (w_nzp_en)
        r_nzp <= w_nzp_next;
    end
  end

  always_comb begin
    o_rs_data = r_regs[i_rs];
    o_rt_data = r_regs[i_rt];
    if (w_wr_en && (i_rd == i_rs))
      o_rs_data = i_wdata;
    if (w_wr_en && (i_rd == i_rt))
      o_rt_data = i_wdata;
  end

  assign o_nzp      = r_nzp;
  assign o_nzp_next = w_nzp_next;

endmodule

// File: tb/tb_lc4_regfile.sv
// Scoreboard bench for lc4_regfile: directed scenarios plus random traffic against an array model.
module tb_lc4_regfile;

  logic        clk;
  logic        rst_n;
  logic        gwe;
  logic [2:0]  i_rs;
  logic [2:0]  i_rt;
  logic [2:0]  i_rd;
  logic        i_rd_we;
  logic [15:0] i_wdata;
  logic        i_nzp_we;
  logic [15:0] o_rs_data;
  logic [15:0] o_rt_data;
  logic [2:0]  o_nzp;
  logic [2:0]  o_nzp_next;

  lc4_regfile #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gwe        (gwe),
    .i_rs       (i_rs),
    .i_rt       (i_rt),
    .i_rd       (i_rd),
    .i_rd_we    (i_rd_we),
    .i_wdata    (i_wdata),
    .i_nzp_we   (i_nzp_we),
    .o_rs_data  (o_rs_data),
    .o_rt_data  (o_rt_data),
    .o_nzp      (o_nzp),
    .o_nzp_next (o_nzp_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] rs;
    logic [15:0] rt;
    logic [2:0]  nzp;
    logic [2:0]  nzp_next;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [15:0] m_regs [8];
  logic [2:0]  m_nzp;

  function automatic logic [2:0] classify(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  // One cycle of stimulus: apply inputs just after the edge, predict, then advance the model.
  task automatic step(input string name, input logic rst, input logic g,
                      input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                      input logic rdwe, input logic [15:0] wd, input logic nzpwe);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; gwe = g; i_rs = rs; i_rt = rt; i_rd = rd;
    i_rd_we = rdwe; i_wdata = wd; i_nzp_we = nzpwe;
    if (!rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_nzp = 3'b010;
    end
    e.name     = name;
    e.rs       = (rst && g && rdwe && rd == rs) ? wd : m_regs[rs];
    e.rt       = (rst && g && rdwe && rd == rt) ? wd : m_regs[rt];
    e.nzp      = m_nzp;
    e.nzp_next = classify(wd);
    sb_q.push_back(e);
    if (rst && g && rdwe)  m_regs[rd] = wd;
    if (rst && g && nzpwe) m_nzp = classify(wd);
  endtask

  task automatic chk(input string name, input string field, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, req);
    end
  endtask

  // Monitor: every falling edge with a pending prediction is one DUT observation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.name, "rs_data",  o_rs_data, e.rs);
        chk(e.name, "rt_data",  o_rt_data, e.rt);
        chk(e.name, "nzp",      {13'd0, o_nzp}, {13'd0, e.nzp});
        chk(e.name, "nzp_next", {13'd0, o_nzp_next}, {13'd0, e.nzp_next});
      end
    end
  end

  initial begin
    int budget;
    rst_n = 1'b0; gwe = 1'b0; i_rs = '0; i_rt = '0; i_rd = '0;
    i_rd_we = 1'b0; i_wdata = '0; i_nzp_we = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_nzp = 3'b010;

    // Reset, then read every index on both ports.
    step("rst_hold", 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 16'h8001, 1'b1);
    step("rst_hold2", 1'b0, 1'b1, 3'd1, 3'd2, 3'd1, 1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 8; i++)
      step("rst_read", 1'b1, 1'b0, 3'(i), 3'(7 - i), 3'd0, 1'b0, 16'h0000, 1'b0);

    // Write then readback.
    step("wr_r3", 1'b1, 1'b1, 3'd0, 3'd1, 3'd3, 1'b1, 16'h1234, 1'b0);
    for (int i = 0; i < 8; i++)
      step("rdback", 1'b1, 1'b0, 3'(i), 3'd3, 3'd0, 1'b0, 16'h0000, 1'b0);

    // Bypass with and without gwe.
    step("wr_r5", 1'b1, 1'b1, 3'd0, 3'd0, 3'd5, 1'b1, 16'h00AA, 1'b0);
    step("byp_on", 1'b1, 1'b1, 3'd5, 3'd5, 3'd5, 1'b1, 16'hBEEF, 1'b0);
    step("wr_r5b", 1'b1, 1'b1, 3'd0, 3'd0, 3'd5, 1'b1, 16'h00AA, 1'b0);
    step("byp_off", 1'b1, 1'b0, 3'd5, 3'd5, 3'd5, 1'b1, 16'hBEEF, 1'b1);
    step("r5_kept", 1'b1, 1'b0, 3'd5, 3'd5, 3'd0, 1'b0, 16'h0000, 1'b0);

    // NZP sequence with no register writes.
    step("nzp_n", 1'b1, 1'b1, 3'd3, 3'd5, 3'd3, 1'b0, 16'h8000, 1'b1);
    step("nzp_z", 1'b1, 1'b1, 3'd3, 3'd5, 3'd3, 1'b0, 16'h0000, 1'b1);
    step("nzp_p", 1'b1, 1'b1, 3'd3, 3'd5, 3'd3, 1'b0, 16'h7FFF, 1'b1);
    step("nzp_hold", 1'b1, 1'b1, 3'd3, 3'd5, 3'd3, 1'b1, 16'hFFFF, 1'b0);
    step("nzp_see", 1'b1, 1'b0, 3'd3, 3'd5, 3'd0, 1'b0, 16'h0001, 1'b0);

    // Back-to-back writes to one register.
    step("b2b_1", 1'b1, 1'b1, 3'd2, 3'd2, 3'd2, 1'b1, 16'h1111, 1'b0);
    step("b2b_2", 1'b1, 1'b1, 3'd2, 3'd0, 3'd2, 1'b1, 16'h2222, 1'b0);
    step("b2b_rd", 1'b1, 1'b0, 3'd2, 3'd2, 3'd0, 1'b0, 16'h0000, 1'b0);

    // Reset while a write to reg7 is pending.
    step("wr_r7", 1'b1, 1'b1, 3'd7, 3'd0, 3'd7, 1'b1, 16'h5555, 1'b1);
    step("r7_set", 1'b1, 1'b0, 3'd7, 3'd7, 3'd0, 1'b0, 16'h0000, 1'b0);
    step("mid_rst", 1'b0, 1'b1, 3'd7, 3'd7, 3'd7, 1'b1, 16'hFFFF, 1'b1);
    step("post_rst", 1'b1, 1'b0, 3'd7, 3'd7, 3'd0, 1'b0, 16'h0000, 1'b0);

    // Random traffic, occasionally dropping gwe or asserting reset.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] wd;
      case ($urandom_range(0, 3))
        0:       wd = 16'h0000;
        1:       wd = 16'h8000 | 16'($urandom);
        default: wd = 16'($urandom);
      endcase
      step("rand", ($urandom_range(0, 59) != 0), ($urandom_range(0, 4) != 0),
           3'($urandom), 3'($urandom), 3'($urandom),
           1'($urandom), wd, 1'($urandom));
    end

    budget = 0;
    while (sb_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc4_regfile.md
# lc4_regfile

Architectural register file and condition-code (NZP) register for the LC4 datapath. It sits directly upstream of the ALU: its two read ports drive the ALU's `i_r1data`/`i_r2data` operands, and its write port takes the writeback result (ALU output, load data or PC+1) back into storage. Writes are gated by the global write enable. A same-cycle write is bypassed to the read ports, so a read of a register being written returns the new value.

## Interface
- `DATA_W`, 16, register and data width
- `ADDR_W`, 3, register index width (2**ADDR_W registers)

- `clk`  input  1  single clock, rising-edge
- `rst_n`  input  1  asynchronous, active-low reset
- `gwe`  input  1  global write enable; when 0, no state changes
- `i_rs`  input  ADDR_W  read port 1 index
- `i_rt`  input  ADDR_W  read port 2 index
- `i_rd`  input  ADDR_W  write port index
- `i_rd_we`  input  1  register write request
- `i_wdata`  input  DATA_W  write data
- `i_nzp_we`  input  1  NZP update request (computed from `i_wdata`)
- `o_rs_data`  output  DATA_W  read port 1 data (combinational)
- `o_rt_data`  output  DATA_W  read port 2 data (combinational)
- `o_nzp`  output  3  registered condition code {N,Z,P}
- `o_nzp_next`  output  3  NZP value that would be latched this cycle (combinational)

One clock; reset is asynchronous and active-low.

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits. R0 is a normal, writable register.
- Effective write: `wr_en = gwe & i_rd_we`. On a rising `clk` with `wr_en=1`, `reg[i_rd] <= i_wdata`.
- Effective NZP write: `nzp_en = gwe & i_nzp_we`. On a rising `clk` with `nzp_en=1`, `o_nzp <= o_nzp_next`.
- NZP encoding from `i_wdata` as signed two's complement:
  - `i_wdata[15]=1` gives 3'b100.
  - `i_wdata==0` gives 3'b010.
  - Otherwise 3'b001.
  - Exactly one bit is ever set.
- `o_nzp_next` is computed from `i_wdata` every cycle, regardless of the enables.
- Read ports:
  - `o_rs_data = (wr_en && i_rd==i_rs) ? i_wdata : reg[i_rs]`.
  - `o_rt_data` is the same, using `i_rt`.
- Both read ports may address the same register, and the write target, simultaneously. Both then return the bypassed value.
- `i_nzp_we` without `i_rd_we` is legal (used by CMP-class instructions). `o_nzp` updates and no register changes.
- `i_rd_we` without `i_nzp_we` is legal. The register updates and `o_nzp` holds.
- When `gwe=0`, all requests are ignored and there is no bypass. Reads return stored values.

## Timing
- Reset (`rst_n=0`, asynchronous, immediate):
  - All registers clear to 16'h0000.
  - `o_nzp` resets to 3'b010.
  - While in reset, `o_rs_data`/`o_rt_data` read 0, with no bypass.
  - `o_nzp_next` still tracks `i_wdata`.
- Reset deassertion: the first edge at which a write can commit is the first rising `clk` with `rst_n=1`.
- A reset asserted mid-cycle discards the pending write. No partial update is allowed.
- Read latency is 0 cycles (combinational from index/storage/bypass).
- Write latency is 1 edge. The stored value is visible without bypass from the cycle after the edge.
- `o_nzp` latency is 1 edge after `nzp_en`.
- Back-to-back writes to the same register on consecutive cycles: each edge commits its own `i_wdata`, and the last one wins.

## Structure
- Shared package `lc4_pkg`:
  - NZP constants `NZP_N=3'b100`, `NZP_Z=3'b010`, `NZP_P=3'b001`.
  - `NZP_RESET=NZP_Z`.
  - Default `DATA_W`/`ADDR_W`.
- The branch unit and the ALU-side decode reuse `lc4_pkg`.
- One sub-module: `lc4_nzp_calc` (DATA_W data in, 3-bit NZP out, purely combinational). It is also reused by the branch-resolution logic.
- Storage is an array with a single write port. Reads are implemented as muxes plus a bypass compare per port.

## Test plan
- Reset then read: hold `rst_n=0`, then release; read all 8 indices on both ports. Every read returns 16'h0000 and `o_nzp=3'b010`.
- Write/readback: `gwe=1`, `i_rd=3`, `i_rd_we=1`, `i_wdata=16'h1234`, one edge. Next cycle `i_rs=3` returns 16'h1234 and all other registers read 0.
- Bypass: reg5=16'h00AA; in one cycle `i_rd=5`, `i_wdata=16'hBEEF`, `wr_en=1`, `i_rs=i_rt=5`. Both ports return 16'hBEEF in that same cycle. Repeat with `gwe=0`: both ports return 16'h00AA and reg5 is unchanged after the edge.
- NZP: `i_nzp_we=1`, `i_rd_we=0`, `gwe=1` with `i_wdata=16'h8000`, then 16'h0000, then 16'h7FFF on consecutive edges. `o_nzp` sequence is 100, 010, 001 and no register changes.
- Reset mid-operation: after writing reg7=16'h5555, assert `rst_n=0` between edges while a write of 16'hFFFF to reg7 is pending. reg7 reads 0 immediately, and after release it still reads 0 with `o_nzp=3'b010`.
